// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of a free-running PWM input
module pwm_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_cnt,
  output logic [WIDTH-1:0] period_cnt,
  output logic             valid,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_lat;
  logic             primed;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // The synchronizer keeps running while en is low so edges stay coherent on re-enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      primed     <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        cnt    <= '0;
        primed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              state  <= HIGH;
              cnt    <= CNT_ONE;
              primed <= 1'b0;
            end
          end
          HIGH: begin
            if (fall) begin
              hi_lat <= cnt;
              cnt    <= cnt + CNT_ONE;
              state  <= LOW;
            end else if (cnt == CNT_MAX) begin
              err   <= 1'b1;
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          LOW: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              state <= HIGH;
              // The period that started at the IDLE exit may be truncated, so it is never reported.
              if (primed) begin
                high_cnt   <= hi_lat;
                period_cnt <= cnt;
                valid      <= 1'b1;
              end else begin
                primed <= 1'b1;
              end
            end else if (cnt == CNT_MAX) begin
              err   <= 1'b1;
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int MAXC = (1 << W) - 1;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         pwm_in;
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic         valid;
  logic         err;

  pwm_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .en(en), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .valid(valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Event-level reference: edges of pwm_in appear two samples later; measurements are timestamp differences.
  bit       samp[$];
  int       n;
  int       ph;
  int       trise;
  int       mhi;
  int       rises;
  logic         exp_valid;
  logic         exp_err;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_per;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  function automatic bit smp(int i);
    if (i < 0 || i >= samp.size()) return 1'b0;
    return samp[i];
  endfunction

  function automatic void model_reset();
    samp.delete();
    n = 0; ph = 0; trise = 0; mhi = 0; rises = 0;
    exp_valid = 1'b0; exp_err = 1'b0; exp_hi = '0; exp_per = '0;
  endfunction

  function automatic void model_edge(bit p, bit e);
    bit r;
    bit f;
    int k;
    r = smp(n - 2) && !smp(n - 3);
    f = !smp(n - 2) && smp(n - 3);
    k = n - trise;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (!e) begin
      ph = 0; rises = 0;
    end else if (ph == 0) begin
      if (r) begin ph = 1; trise = n; rises = 1; end
    end else if (ph == 1) begin
      if (f) begin mhi = k; ph = 2; end
      else if (k == MAXC) begin exp_err = 1'b1; ph = 0; end
    end else begin
      if (r) begin
        if (rises >= 2) begin
          exp_valid = 1'b1; exp_hi = W'(mhi); exp_per = W'(k);
        end
        rises++; trise = n; ph = 1;
      end else if (k == MAXC) begin
        exp_err = 1'b1; ph = 0;
      end
    end
    samp.push_back(p);
    n++;
  endfunction

  task automatic check_outputs();
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("err", 32'(err), 32'(exp_err));
    chk("high_cnt", 32'(high_cnt), 32'(exp_hi));
    chk("period_cnt", 32'(period_cnt), 32'(exp_per));
  endtask

  task automatic step(input bit p, input bit e);
    pwm_in = p;
    en     = e;
    @(posedge clk);
    model_edge(p, e);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input bit p);
    rstn   = 1'b0;
    pwm_in = p;
    en     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    chk("reset_high_cnt", 32'(high_cnt), 0);
    chk("reset_period_cnt", 32'(period_cnt), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_err", 32'(err), 0);
  endtask

  task automatic en_clear();
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
  endtask

  task automatic run_pattern(input int per, input int hi, input int off, input int ncyc,
                             input int elo_s, input int elo_e,
                             output int nval, output int nerr, output int first_v,
                             output int first_after, output bit spacing_ok);
    int last_v;
    int pi;
    bit p;
    bit e;
    nval = 0; nerr = 0; first_v = -1; first_after = -1; spacing_ok = 1'b1; last_v = -1;
    for (int i = 0; i < ncyc; i++) begin
      pi = i % per;
      p  = (pi >= off) && (pi < off + hi);
      e  = !(i >= elo_s && i <= elo_e);
      step(p, e);
      if (valid) begin
        nval++;
        if (first_v < 0) first_v = i;
        if (first_after < 0 && i > elo_e) first_after = i;
        if (last_v >= 0 && (i - last_v) != per) spacing_ok = 1'b0;
        last_v = i;
      end
      if (err) nerr++;
    end
  endtask

  typedef struct {
    int per;
    int hi;
    int off;
    int nper;
    int exp_hi;
    int exp_per;
    int exp_nval;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   nval, nerr, first_v, first_after;
    bit   spacing_ok;
    int   plen;
    bit   plevel;

    tbl[0] = '{16, 4,  4, 6, 4,  16, 4};
    tbl[1] = '{20, 1,  0, 6, 1,  20, 4};
    tbl[2] = '{20, 10, 0, 6, 10, 20, 4};
    tbl[3] = '{20, 19, 0, 6, 19, 20, 4};

    rstn = 1'b0; en = 1'b0; pwm_in = 1'b0;
    model_reset();
    do_reset(1'b0);

    foreach (tbl[v]) begin
      en_clear();
      run_pattern(tbl[v].per, tbl[v].hi, tbl[v].off, tbl[v].nper * tbl[v].per, -1, -1,
                  nval, nerr, first_v, first_after, spacing_ok);
      chk($sformatf("vec%0d_nval", v), nval, tbl[v].exp_nval);
      chk($sformatf("vec%0d_nerr", v), nerr, 0);
      chk($sformatf("vec%0d_first_valid", v), first_v, 2 * tbl[v].per + tbl[v].off + 2);
      chk($sformatf("vec%0d_spacing", v), 32'(spacing_ok), 1);
      chk($sformatf("vec%0d_high_cnt", v), 32'(high_cnt), tbl[v].exp_hi);
      chk($sformatf("vec%0d_period_cnt", v), 32'(period_cnt), tbl[v].exp_per);
    end

    // Constant high after a rise from IDLE must saturate exactly once and leave outputs alone.
    en_clear();
    nval = 0; nerr = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1);
      if (valid) nval++;
      if (err) nerr++;
    end
    chk("sat_err_count", nerr, 1);
    chk("sat_valid_count", nval, 0);
    chk("sat_high_cnt", 32'(high_cnt), 19);
    chk("sat_period_cnt", 32'(period_cnt), 20);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

    // pwm_in high across reset release; truncated first period must be discarded.
    do_reset(1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    run_pattern(16, 4, 0, 96, -1, -1, nval, nerr, first_v, first_after, spacing_ok);
    chk("rst_hi_first_valid", first_v, 34);
    chk("rst_hi_high_cnt", 32'(high_cnt), 4);
    chk("rst_hi_period_cnt", 32'(period_cnt), 16);

    // en low for 5 cycles mid-period.
    en_clear();
    run_pattern(16, 4, 0, 128, 54, 58, nval, nerr, first_v, first_after, spacing_ok);
    chk("en_gap_first_valid", first_v, 34);
    chk("en_gap_resume", first_after, 98);
    chk("en_gap_nval", nval, 4);
    chk("en_gap_nerr", nerr, 0);
    chk("en_gap_high_cnt", 32'(high_cnt), 4);

    // Asynchronous reset while in HIGH.
    en_clear();
    run_pattern(16, 4, 0, 48, -1, -1, nval, nerr, first_v, first_after, spacing_ok);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_high_cnt", 32'(high_cnt), 0);
    chk("async_period_cnt", 32'(period_cnt), 0);
    chk("async_valid", 32'(valid), 0);
    chk("async_err", 32'(err), 0);
    do_reset(1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    run_pattern(16, 4, 0, 96, -1, -1, nval, nerr, first_v, first_after, spacing_ok);
    chk("async_rel_first_valid", first_v, 34);
    chk("async_rel_high_cnt", 32'(high_cnt), 4);
    chk("async_rel_period_cnt", 32'(period_cnt), 16);

    // Random phase lengths, occasional long phases and en drops, checked every cycle by the model.
    en_clear();
    plevel = 1'b0;
    for (int seg = 0; seg < 160; seg++) begin
      plevel = ~plevel;
      if ($urandom_range(19, 0) == 0) plen = $urandom_range(200, 41);
      else plen = $urandom_range(40, 1);
      for (int i = 0; i < plen; i++) begin
        if ($urandom_range(299, 0) == 0) step(plevel, 1'b0);
        else step(plevel, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
